// File: rtl/ibis_pkg.sv
// Shared types and constants for the ibis mapper sequencer.
// Also holds the 10-phase mapper ring length and the identity matrix element.
package ibis_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RENDER = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;

  localparam int                MAP_PHASES      = 10;
  localparam logic [3:0]        LAST_PHASE      = 4'(MAP_PHASES - 1);
  localparam logic signed [11:0] MATRIX_IDENTITY = 12'sh010;

endpackage

// File: rtl/ibis_pixel_outbuf.sv
// One-entry pixel output register: capture marks a pixel pending, and mapper data is copied out when the slot frees.
// Pending-to-valid takes one cycle; outputs hold steady while valid is high and ready is low.
module ibis_pixel_outbuf #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [WIDTH-1:0] cap_x,
  input  logic [WIDTH-1:0] cap_y,
  input  logic             cap_last,
  input  logic [8:0]       pix_in,
  output logic             pending,
  output logic             valid,
  input  logic             ready,
  output logic [8:0]       data,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             last,
  output logic             done
);

  logic [WIDTH-1:0] pend_x;
  logic [WIDTH-1:0] pend_y;
  logic             pend_last;
  logic             move;

  assign move = pending && (!valid || ready);
  assign done = valid && ready && last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      pend_last <= 1'b0;
      valid     <= 1'b0;
      data      <= '0;
      x         <= '0;
      y         <= '0;
      last      <= 1'b0;
    end else begin
      if (capture) begin
        pending   <= 1'b1;
        pend_x    <= cap_x;
        pend_y    <= cap_y;
        pend_last <= cap_last;
      end else if (move) begin
        pending <= 1'b0;
      end

      // The mapper holds its result while the ring is parked, so the copy may lag the capture.
      if (move) begin
        valid <= 1'b1;
        data  <= pix_in;
        x     <= pend_x;
        y     <= pend_y;
        last  <= pend_last;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ibis_mapper_sequencer.sv
// Drives one ibis_forward_mapper: texel upload passes (LOAD) and a raster scan of one pass per pixel (RENDER).
// First pixel appears 11 cycles after its phase-0 enable; a stalled pixel stream parks the ring at phase 9.
module ibis_mapper_sequencer
  import ibis_pkg::*;
#(
  parameter int TILE_SIZE_POW2 = 5,
  parameter int WIDTH          = 10,
  parameter int SCAN_W         = 128,
  parameter int SCAN_H         = 128
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cmd_load,
  input  logic                        cmd_render,
  input  logic signed [11:0]          cfg_matrix_a,
  input  logic signed [11:0]          cfg_matrix_b,
  input  logic signed [11:0]          cfg_matrix_c,
  input  logic signed [11:0]          cfg_matrix_d,
  input  logic                        s_texel_valid,
  output logic                        s_texel_ready,
  input  logic [2*TILE_SIZE_POW2-1:0] s_texel_addr,
  input  logic [8:0]                  s_texel_data,
  input  logic                        s_texel_last,
  output logic                        m_pix_valid,
  input  logic                        m_pix_ready,
  output logic [8:0]                  m_pix_data,
  output logic [WIDTH-1:0]            m_pix_x,
  output logic [WIDTH-1:0]            m_pix_y,
  output logic                        m_pix_last,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        phase_err,
  output logic                        map_enable,
  output logic [3:0]                  map_write_matrix,
  output logic                        map_write_texels,
  output logic [WIDTH-1:0]            map_x,
  output logic [WIDTH-1:0]            map_y,
  output logic signed [11:0]          map_matrixA,
  output logic signed [11:0]          map_matrixB,
  output logic signed [11:0]          map_matrixC,
  output logic signed [11:0]          map_matrixD,
  output logic [2*TILE_SIZE_POW2-1:0] map_in_address,
  output logic [8:0]                  map_in_data,
  input  logic [8:0]                  map_out_data,
  input  logic                        map_cycle_complete
);

  localparam logic [WIDTH-1:0] X_LAST = WIDTH'(SCAN_W - 1);
  localparam logic [WIDTH-1:0] Y_LAST = WIDTH'(SCAN_H - 1);

  seq_state_t state, state_nxt;

  logic [3:0]         phase;
  logic [WIDTH-1:0]   x_cnt;
  logic [WIDTH-1:0]   y_cnt;
  logic signed [11:0] cfg_a, cfg_b, cfg_c, cfg_d;
  logic               first_pass;
  logic               load_last;
  logic               pass_last;
  logic               launch;
  logic               capture;
  logic               pix_pending;
  logic               scan_end;

  assign scan_end = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
  assign launch   = map_enable && (phase == 4'd0);
  assign capture  = map_enable && (phase == LAST_PHASE) &&
                    ((state == RENDER) || (state == DRAIN));
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    map_enable    = 1'b0;
    s_texel_ready = (state == LOAD) && (phase == 4'd0);

    if (phase == 4'd0) begin
      map_enable = ((state == LOAD) && s_texel_valid) || (state == RENDER);
    end else if (phase == LAST_PHASE) begin
      map_enable = !pix_pending;
    end else begin
      map_enable = 1'b1;
    end

    case (state)
      IDLE: begin
        if (cmd_load) begin
          state_nxt = LOAD;
        end else if (cmd_render) begin
          state_nxt = RENDER;
        end
      end
      LOAD: begin
        if (map_enable && (phase == LAST_PHASE) && load_last) begin
          state_nxt = IDLE;
        end
      end
      RENDER: begin
        if (launch && scan_end) begin
          state_nxt = DRAIN;
        end
      end
      // Ring back at phase 0 means the final pass has been captured, not just launched.
      DRAIN: begin
        if ((phase == 4'd0) && !pix_pending && !m_pix_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state            <= IDLE;
      phase            <= 4'd0;
      x_cnt            <= '0;
      y_cnt            <= '0;
      cfg_a            <= MATRIX_IDENTITY;
      cfg_b            <= 12'sh000;
      cfg_c            <= 12'sh000;
      cfg_d            <= MATRIX_IDENTITY;
      first_pass       <= 1'b0;
      load_last        <= 1'b0;
      pass_last        <= 1'b0;
      phase_err        <= 1'b0;
      map_write_matrix <= 4'h0;
      map_write_texels <= 1'b0;
      map_x            <= '0;
      map_y            <= '0;
      map_matrixA      <= 12'sh000;
      map_matrixB      <= 12'sh000;
      map_matrixC      <= 12'sh000;
      map_matrixD      <= 12'sh000;
      map_in_address   <= '0;
      map_in_data      <= '0;
    end else begin
      state     <= state_nxt;
      phase_err <= phase_err | (map_cycle_complete != (phase == LAST_PHASE));

      if (map_enable) begin
        phase <= (phase == LAST_PHASE) ? 4'd0 : phase + 4'd1;
      end

      if (state == IDLE) begin
        if (cmd_load) begin
          load_last <= 1'b0;
        end else if (cmd_render) begin
          x_cnt      <= '0;
          y_cnt      <= '0;
          cfg_a      <= cfg_matrix_a;
          cfg_b      <= cfg_matrix_b;
          cfg_c      <= cfg_matrix_c;
          cfg_d      <= cfg_matrix_d;
          first_pass <= 1'b1;
        end
      end

      if (launch && (state == LOAD)) begin
        map_in_address   <= s_texel_addr;
        map_in_data      <= s_texel_data;
        map_write_texels <= 1'b1;
        map_write_matrix <= 4'h0;
        load_last        <= s_texel_last;
      end

      if (launch && (state == RENDER)) begin
        map_x            <= x_cnt;
        map_y            <= y_cnt;
        map_write_texels <= 1'b0;
        map_write_matrix <= first_pass ? 4'hF : 4'h0;
        first_pass       <= 1'b0;
        map_matrixA      <= cfg_a;
        map_matrixB      <= cfg_b;
        map_matrixC      <= cfg_c;
        map_matrixD      <= cfg_d;
        pass_last        <= scan_end;
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

  ibis_pixel_outbuf #(
    .WIDTH(WIDTH)
  ) u_outbuf (
    .clk     (aclk),
    .rst_n   (aresetn),
    .capture (capture),
    .cap_x   (map_x),
    .cap_y   (map_y),
    .cap_last(pass_last),
    .pix_in  (map_out_data),
    .pending (pix_pending),
    .valid   (m_pix_valid),
    .ready   (m_pix_ready),
    .data    (m_pix_data),
    .x       (m_pix_x),
    .y       (m_pix_y),
    .last    (m_pix_last),
    .done    (frame_done)
  );

endmodule
